// File: rtl/cnoc_copy_dma.sv
//============================================================================
// cnoc_copy_dma : single-channel CNOC copy engine, read-chunk then write-chunk
//                 through a MAX_BURST-deep staging buffer.
// Option macro  : CNOC_COPY_4K_SPLIT_EN (split chunks at 4 KB boundaries)
// Revision      : 1.0
//============================================================================
`default_nettype none

package cnoc_pkg;
  localparam int CNOC_DATAW = 64;
  localparam int CNOC_ADDRW = 32;
  localparam int AXI_IDW    = 4;

  typedef struct packed {
    logic [AXI_IDW-1:0]    id;
    logic [CNOC_ADDRW-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic                  user;
  } cnoc_ax_s;

  typedef struct packed {
    logic [CNOC_DATAW-1:0]   data;
    logic [CNOC_DATAW/8-1:0] strb;
    logic                    last;
    logic                    user;
  } cnoc_w_s;

  typedef struct packed {
    logic [AXI_IDW-1:0] id;
    logic [1:0]         resp;
    logic               user;
  } cnoc_b_s;

  typedef struct packed {
    logic [AXI_IDW-1:0]    id;
    logic [CNOC_DATAW-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic                  user;
  } cnoc_r_s;

  typedef struct packed {
    logic     aw_valid;
    cnoc_ax_s aw;
    logic     w_valid;
    cnoc_w_s  w;
    logic     b_ready;
    logic     ar_valid;
    cnoc_ax_s ar;
    logic     r_ready;
  } cnoc_req_s;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    cnoc_b_s b;
    logic    r_valid;
    cnoc_r_s r;
  } cnoc_resp_s;
endpackage

module cnoc_copy_dma
  import cnoc_pkg::*;
#(
  parameter int                  DATA_WIDTH = CNOC_DATAW,
  parameter int                  ADDR_WIDTH = CNOC_ADDRW,
  parameter int                  ID_WIDTH   = AXI_IDW,
  parameter logic [ID_WIDTH-1:0] AXI_ID     = '0,
  parameter int                  MAX_BURST  = 16,
  parameter int                  CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output cnoc_req_s             req,
  input  cnoc_resp_s            resp
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int BSH        = $clog2(BEAT_BYTES);
  localparam int LENW       = $clog2(MAX_BURST) + 1;
  localparam int IDXW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int MW         = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [LENW-1:0]       len_q, len_d;
  logic [LENW-1:0]       rcnt_q, rcnt_d;
  logic [LENW-1:0]       wcnt_q, wcnt_d;
  logic                  error_q, error_d;

  logic [DATA_WIDTH-1:0] stage_mem [MAX_BURST];
  logic                  stage_we;
  logic [CNT_WIDTH-1:0]  rem_next;
  logic [MW-1:0]         chunk_len;
  logic                  w_last;
  logic                  resp_unused;

`ifdef CNOC_COPY_4K_SPLIT_EN
  localparam int PAGE_BEATS = 4096 / BEAT_BYTES;
  logic [MW-1:0] src_room;
  logic [MW-1:0] dst_room;
`endif

  // Chunk length is derived from the live src/dst/remaining registers, which
  // stay frozen while AR is pending, so ar.len is stable until the handshake.
  always_comb begin
    chunk_len = (MW'(rem_q) < MW'(MAX_BURST)) ? MW'(rem_q) : MW'(MAX_BURST);
`ifdef CNOC_COPY_4K_SPLIT_EN
    src_room = MW'(PAGE_BEATS) - MW'(src_q[11:BSH]);
    dst_room = MW'(PAGE_BEATS) - MW'(dst_q[11:BSH]);
    if (src_room < chunk_len) chunk_len = src_room;
    if (dst_room < chunk_len) chunk_len = dst_room;
`endif
  end

  assign w_last      = (wcnt_q == (len_q - LENW'(1)));
  assign rem_next    = rem_q - CNT_WIDTH'(len_q);
  assign resp_unused = ^{resp.b.id, resp.b.resp[0], resp.b.user,
                         resp.r.id, resp.r.resp[0], resp.r.user};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stage_we) stage_mem[rcnt_q[IDXW-1:0]] <= resp.r.data[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    rem_d    = rem_q;
    len_d    = len_q;
    rcnt_d   = rcnt_q;
    wcnt_d   = wcnt_q;
    error_d  = error_q;
    stage_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = num_beats;
          error_d = 1'b0;
          state_d = (num_beats == '0) ? S_DONE : S_AR;
        end
      end
      S_AR: begin
        if (resp.ar_ready) begin
          len_d   = LENW'(chunk_len);
          rcnt_d  = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        if (resp.r_valid) begin
          // Beats past the granted length have no buffer slot: drop and flag.
          if (rcnt_q < len_q) begin
            stage_we = 1'b1;
            rcnt_d   = rcnt_q + LENW'(1);
          end else begin
            error_d = 1'b1;
          end
          if (resp.r.resp[1]) error_d = 1'b1;
          if (resp.r.last) state_d = S_AW;
        end
      end
      S_AW: begin
        if (resp.aw_ready) begin
          wcnt_d  = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (resp.w_ready) begin
          wcnt_d = wcnt_q + LENW'(1);
          if (w_last) state_d = S_B;
        end
      end
      S_B: begin
        if (resp.b_valid) begin
          src_d = src_q + (ADDR_WIDTH'(len_q) << BSH);
          dst_d = dst_q + (ADDR_WIDTH'(len_q) << BSH);
          rem_d = rem_next;
          if (resp.b.resp[1]) error_d = 1'b1;
          state_d = ((rem_next != '0) && !error_q && !resp.b.resp[1]) ? S_AR : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req   = '0;
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    error = error_q;
    case (state_q)
      S_AR: begin
        req.ar_valid = 1'b1;
        req.ar.id    = AXI_IDW'(AXI_ID);
        req.ar.addr  = CNOC_ADDRW'(src_q);
        req.ar.len   = 8'(chunk_len - MW'(1));
        req.ar.size  = 3'(BSH);
        req.ar.burst = 2'b01;
      end
      S_R: req.r_ready = 1'b1;
      S_AW: begin
        req.aw_valid = 1'b1;
        req.aw.id    = AXI_IDW'(AXI_ID);
        req.aw.addr  = CNOC_ADDRW'(dst_q);
        req.aw.len   = 8'(len_q - LENW'(1));
        req.aw.size  = 3'(BSH);
        req.aw.burst = 2'b01;
      end
      S_W: begin
        req.w_valid = 1'b1;
        req.w.data  = CNOC_DATAW'(stage_mem[wcnt_q[IDXW-1:0]]);
        req.w.strb  = '1;
        req.w.last  = w_last;
      end
      S_B:     req.b_ready = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cnoc_copy_dma.sv
//============================================================================
// tb_cnoc_copy_dma : table-driven bench with an AXI RAM target model and a
//                    scoreboard of expected AR/AW/W traffic.
// Revision         : 1.0
//============================================================================
`default_nettype none

module tb_cnoc_copy_dma;
  import cnoc_pkg::*;

  localparam int         DW = 64;
  localparam int         AW = 32;
  localparam int         MB = 16;
  localparam int         CW = 16;
  localparam logic [3:0] ID = 4'h0;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          n;
    int          err_r_chunk;
    int          err_r_beat;
    int          err_b_chunk;
    bit          stall;
    bit          glitch;
    int          exp_chunks;
    bit          exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [CW-1:0] num_beats = '0;
  logic          busy, done, error;
  cnoc_req_s     req;
  cnoc_resp_s    resp;

  cnoc_copy_dma #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(AXI_IDW), .AXI_ID(ID),
    .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .num_beats(num_beats), .busy(busy), .done(done),
    .error(error), .req(req), .resp(resp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem [0:8191];
  cnoc_ax_s    exp_ar_q [$];
  cnoc_ax_s    exp_aw_q [$];
  logic [64:0] exp_w_q  [$];

  bit          rd_active, wr_active, b_pend, stall_en;
  bit          exp_aw_next, exp_w_next, exp_ar_next;
  logic [31:0] rd_addr, wr_addr;
  logic [1:0]  b_resp_pend;
  int          rd_left, rd_beat, chunk_idx, b_count, done_count;
  int          inj_r_chunk, inj_r_beat, inj_b_chunk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cnoc_ax_s mk_ax(input logic [31:0] a, input int l);
    cnoc_ax_s x;
    x       = '0;
    x.id    = ID;
    x.addr  = a;
    x.len   = 8'(l);
    x.size  = 3'd3;
    x.burst = 2'b01;
    return x;
  endfunction

  // RAM target: decisions are made on the falling edge, when the DUT outputs
  // for the coming rising edge are already settled.
  task automatic slave_step();
    cnoc_ax_s    ax;
    logic [64:0] ew;
    if (!arst_n) begin
      resp = '0; rd_active = 0; wr_active = 0; b_pend = 0;
      exp_aw_next = 0; exp_w_next = 0; exp_ar_next = 0;
      return;
    end
    if (done) done_count++;
    if (exp_aw_next) begin check("aw_after_rlast", req.aw_valid, 1); exp_aw_next = 0; end
    if (exp_w_next)  begin check("w_after_aw", req.w_valid, 1);      exp_w_next  = 0; end
    if (exp_ar_next) begin check("ar_after_b", req.ar_valid, 1);     exp_ar_next = 0; end

    resp.b_valid = b_pend;
    resp.b.resp  = b_resp_pend;
    resp.b.id    = ID;
    if (b_pend && req.b_ready) begin
      b_pend = 0;
      b_count++;
      if (exp_ar_q.size() > 0) exp_ar_next = 1;
    end

    resp.w_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (req.w_valid && resp.w_ready) begin
      if (!wr_active || exp_w_q.size() == 0) begin
        check("w_unexpected", 1, 0);
      end else begin
        ew = exp_w_q.pop_front();
        check("w_data", req.w.data, ew[63:0]);
        check("w_last", req.w.last, ew[64]);
        mem[wr_addr[15:3]] = req.w.data;
        wr_addr = wr_addr + 32'd8;
        if (req.w.last) begin
          check("w_strb", req.w.strb, 8'hFF);
          wr_active   = 0;
          b_pend      = 1;
          b_resp_pend = (chunk_idx == inj_b_chunk) ? 2'b10 : 2'b00;
        end
      end
    end

    resp.aw_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (req.aw_valid && resp.aw_ready) begin
      if (exp_aw_q.size() == 0) begin
        check("aw_unexpected", 1, 0);
      end else begin
        ax = exp_aw_q.pop_front();
        check("aw_fields", req.aw, ax);
      end
      wr_active  = 1;
      wr_addr    = req.aw.addr;
      exp_w_next = 1;
    end

    if (rd_active) begin
      resp.r_valid = 1'b1;
      resp.r.id    = ID;
      resp.r.data  = mem[rd_addr[15:3]];
      resp.r.last  = (rd_left == 1);
      resp.r.resp  = (chunk_idx == inj_r_chunk && rd_beat == inj_r_beat) ? 2'b10 : 2'b00;
      if (req.r_ready) begin
        rd_addr = rd_addr + 32'd8;
        rd_left--;
        rd_beat++;
        if (rd_left == 0) begin rd_active = 0; exp_aw_next = 1; end
      end
    end else begin
      resp.r_valid = 1'b0;
    end

    resp.ar_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (req.ar_valid && resp.ar_ready) begin
      if (exp_ar_q.size() == 0) begin
        check("ar_unexpected", 1, 0);
      end else begin
        ax = exp_ar_q.pop_front();
        check("ar_fields", req.ar, ax);
      end
      chunk_idx++;
      rd_active = 1;
      rd_addr   = req.ar.addr;
      rd_left   = int'(req.ar.len) + 1;
      rd_beat   = 1;
    end
  endtask

  initial forever begin
    @(negedge clk);
    slave_step();
  end

  task automatic push_model(input vec_t v);
    int s, d, rem, len, chunks;
    exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    chunk_idx = 0; b_count = 0; done_count = 0;
    inj_r_chunk = v.err_r_chunk; inj_r_beat = v.err_r_beat;
    inj_b_chunk = v.err_b_chunk; stall_en = v.stall;
    s = int'(v.src); d = int'(v.dst); rem = v.n; chunks = 0;
    while (rem > 0) begin
      len = (rem < MB) ? rem : MB;
`ifdef CNOC_COPY_4K_SPLIT_EN
      if ((4096 - (s % 4096)) / 8 < len) len = (4096 - (s % 4096)) / 8;
      if ((4096 - (d % 4096)) / 8 < len) len = (4096 - (d % 4096)) / 8;
`endif
      chunks++;
      exp_ar_q.push_back(mk_ax(32'(s), len - 1));
      exp_aw_q.push_back(mk_ax(32'(d), len - 1));
      for (int i = 0; i < len; i++) exp_w_q.push_back({i == len - 1, mem[(s / 8) + i]});
      s += len * 8; d += len * 8; rem -= len;
      if (chunks == v.err_r_chunk || chunks == v.err_b_chunk) break;
    end
  endtask

  task automatic run_copy(input vec_t v);
    bit got_done;
    int mism;
    push_model(v);
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; num_beats = CW'(v.n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("error_cleared", error, 0);
    check("busy_rise", busy, 1);
    check("ar_valid_first", req.ar_valid, v.n != 0);
    if (v.n == 0) check("zero_done_next_cycle", done, 1);
    if (v.glitch) begin
      @(negedge clk);
      src_addr = 32'h500; dst_addr = 32'h7800; num_beats = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got_done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin got_done = 1; break; end
      @(negedge clk);
    end
    check("done_seen", got_done, 1);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("busy_fall", busy, 0);
    repeat (3) @(negedge clk);
    check("done_count", done_count, 1);
    check("error_final", error, v.exp_err);
    check("b_count", b_count, v.exp_chunks);
    check("sb_drained", exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);
    if (!v.exp_err) begin
      mism = 0;
      for (int i = 0; i < v.n; i++)
        if (mem[(v.dst / 8) + i] !== mem[(v.src / 8) + i]) mism++;
      check("dst_data", mism, 0);
    end
  endtask

  vec_t vecs [9];
  vec_t vrst, vpost;

  initial begin
    bit seen_w;
    resp = '0;
    for (int i = 0; i < 8192; i++) mem[i] = {16'hC0DE, 16'(i), 32'(i) * 32'h9E3779B9};
    mem[0] = 64'h11; mem[1] = 64'h22; mem[2] = 64'h33; mem[3] = 64'h44;

    //          src       dst       n   rc rb bc st gl chunks err
    vecs[0] = '{32'h000, 32'h0800, 4,  0, 0, 0, 0, 0, 1, 0};
    vecs[1] = '{32'h000, 32'h1000, 40, 0, 0, 0, 0, 0, 3, 0};
`ifdef CNOC_COPY_4K_SPLIT_EN
    vecs[2] = '{32'hFF0, 32'h2000, 4,  0, 0, 0, 0, 0, 2, 0};
`else
    vecs[2] = '{32'hFF0, 32'h2000, 4,  0, 0, 0, 0, 0, 1, 0};
`endif
    vecs[3] = '{32'h000, 32'h3000, 40, 1, 2, 0, 0, 0, 1, 1};
    vecs[4] = '{32'h100, 32'h3800, 20, 0, 0, 0, 0, 0, 2, 0};
    vecs[5] = '{32'h200, 32'h4000, 20, 0, 0, 1, 0, 0, 1, 1};
    vecs[6] = '{32'h400, 32'h5000, 37, 0, 0, 0, 1, 0, 3, 0};
    vecs[7] = '{32'h600, 32'h5800, 0,  0, 0, 0, 0, 0, 0, 0};
    vecs[8] = '{32'h700, 32'h6000, 4,  0, 0, 0, 0, 1, 1, 0};
    vrst    = '{32'h000, 32'h6800, 16, 0, 0, 0, 0, 0, 1, 0};
    vpost   = '{32'h080, 32'h7000, 16, 0, 0, 0, 0, 0, 1, 0};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_req_zero", |req, 0);
    arst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_req_zero", |req, 0);

    for (int k = 0; k < 9; k++) run_copy(vecs[k]);
    check("pattern_last_beat", mem[(32'h800 / 8) + 3], 64'h44);

    // Reset asserted in the middle of the write phase.
    push_model(vrst);
    @(negedge clk);
    src_addr = vrst.src; dst_addr = vrst.dst; num_beats = CW'(vrst.n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_w = 0;
    for (int i = 0; i < 200; i++) begin
      if (req.w_valid) begin seen_w = 1; break; end
      @(negedge clk);
    end
    check("reached_w", seen_w, 1);
    #2 arst_n = 1'b0;
    #1;
    check("mid_rst_valids", {req.ar_valid, req.aw_valid, req.w_valid, req.r_ready, req.b_ready}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    run_copy(vpost);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
